// File: rtl/display_pkg.sv
// Shared constants for the paged hex display: active-low glyphs (bit 0 = a .. bit 6 = g)
// and the page-count helper.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic int unsigned num_pages(input int unsigned num_ch,
                                            input int unsigned ch_per_page);
    return (num_ch + ch_per_page - 1) / ch_per_page;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder (bit 0 = a .. bit 6 = g).
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_page_display.sv
// Paged seven-segment front end: snapshots the channel bus, pages through it on a
// synchronised button edge or scroll timer, and drives registered active-low digits.
module hex_page_display
  import display_pkg::*;
#(
  parameter int unsigned NUM_CH        = 5,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned DIGITS_PER_CH = 2,
  parameter int unsigned SCROLL_DIV    = 50_000_000,
  localparam int unsigned CH_PER_PAGE  = NUM_DIGITS / DIGITS_PER_CH,
  localparam int unsigned NUM_PAGES    = num_pages(NUM_CH, CH_PER_PAGE),
  localparam int unsigned PAGE_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                         Clock,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  input  logic                         next_page,
  input  logic                         auto_mode,
  input  logic                         freeze,
  output logic [NUM_DIGITS*7-1:0]      hex_seg,
  output logic [PAGE_W-1:0]            page,
  output logic                         frozen
);

  localparam int unsigned SLOT_W = 4 * DIGITS_PER_CH;
  localparam int unsigned CNT_W  = $clog2(SCROLL_DIV);

  logic                      r_sync1, r_sync2, r_sync_prev, r_btn_pulse;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_d;
  logic [PAGE_W-1:0]         r_page;
  logic [PAGE_W-1:0]         w_page_d;
  logic [NUM_CH*DATA_W-1:0]  r_snap;
  logic                      r_frozen;
  logic [NUM_DIGITS*7-1:0]   r_hex;
  logic [NUM_DIGITS*7-1:0]   w_seg_d;
  logic                      w_tc;
  logic                      w_advance;

  // Slot contents per page; slots past the last channel are flagged unused.
  logic [SLOT_W-1:0] w_slot_val  [NUM_PAGES][CH_PER_PAGE];
  logic              w_slot_used [NUM_PAGES][CH_PER_PAGE];
  logic [NUM_CH-1:0] w_unused_hi;

  always_comb begin
    w_tc      = auto_mode && (r_cnt == CNT_W'(SCROLL_DIV - 1));
    w_advance = w_tc || r_btn_pulse;
  end

  always_comb begin
    w_cnt_d = r_cnt + CNT_W'(1);
    if (!auto_mode || w_advance) begin
      w_cnt_d = '0;
    end
  end

  always_comb begin
    w_page_d = r_page;
    if (w_advance) begin
      if (NUM_PAGES <= 1 || r_page == PAGE_W'(NUM_PAGES - 1)) begin
        w_page_d = '0;
      end else begin
        w_page_d = r_page + PAGE_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_btn_pulse <= 1'b0;
      r_cnt       <= '0;
      r_page      <= '0;
    end else begin
      r_sync1     <= next_page;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_btn_pulse <= r_sync2 & ~r_sync_prev;
      r_cnt       <= w_cnt_d;
      r_page      <= w_page_d;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_snap   <= '0;
      r_frozen <= 1'b0;
      r_hex    <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      if (!freeze) begin
        r_snap <= ch_data;
      end
      r_frozen <= freeze;
      r_hex    <= w_seg_d;
    end
  end

  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
    for (genvar s = 0; s < CH_PER_PAGE; s++) begin : g_slot
      if (p * CH_PER_PAGE + s < NUM_CH) begin : g_used
        assign w_slot_val[p][s]  = r_snap[(p*CH_PER_PAGE+s)*DATA_W +: SLOT_W];
        assign w_slot_used[p][s] = 1'b1;
      end else begin : g_unused
        assign w_slot_val[p][s]  = '0;
        assign w_slot_used[p][s] = 1'b0;
      end
    end
  end

  // Only the low SLOT_W bits of each channel are ever shown.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_hi
    if (SLOT_W < DATA_W) begin : g_drop
      assign w_unused_hi[k] = ^r_snap[k*DATA_W+SLOT_W +: DATA_W-SLOT_W];
    end else begin : g_none
      assign w_unused_hi[k] = 1'b0;
    end
  end

  // Slot 0 is leftmost; within a slot the most significant nibble is leftmost.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam int unsigned SLOT = CH_PER_PAGE - 1 - d / DIGITS_PER_CH;
    localparam int unsigned NIB  = d % DIGITS_PER_CH;
    logic [6:0] w_glyph;

    hex7seg u_hex7seg (
      .i_nibble (w_slot_val[r_page][SLOT][NIB*4 +: 4]),
      .o_seg    (w_glyph)
    );

    assign w_seg_d[7*d +: 7] = w_slot_used[r_page][SLOT] ? w_glyph : SEG_BLANK;
  end

  assign hex_seg = r_hex;
  assign page    = r_page;
  assign frozen  = r_frozen;

endmodule

// File: tb/tb_hex_page_display.sv
// Randomised and directed bench for hex_page_display against a behavioural display model.
module tb_hex_page_display;

  localparam int NCH = 5;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [79:0] ch_data = '0;
  logic        btn = 1'b0;
  logic        auto_m = 1'b0;
  logic        frz = 1'b0;
  logic [55:0] hex_seg;
  logic [0:0]  page;
  logic        frozen;

  logic [47:0] ch_data3 = {16'h9ABC, 16'h5678, 16'h1234};
  logic        btn3 = 1'b0;
  logic [27:0] hex3;
  logic [1:0]  page3;
  logic        frozen3;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  hex_page_display #(
    .NUM_CH(5), .DATA_W(16), .NUM_DIGITS(8), .DIGITS_PER_CH(2), .SCROLL_DIV(DIV)
  ) u_dut (
    .Clock(clk), .reset(rst_n), .ch_data(ch_data), .next_page(btn), .auto_mode(auto_m),
    .freeze(frz), .hex_seg(hex_seg), .page(page), .frozen(frozen)
  );

  hex_page_display #(
    .NUM_CH(3), .DATA_W(16), .NUM_DIGITS(4), .DIGITS_PER_CH(4), .SCROLL_DIV(DIV)
  ) u_dut3 (
    .Clock(clk), .reset(rst_n), .ch_data(ch_data3), .next_page(btn3), .auto_mode(1'b0),
    .freeze(1'b0), .hex_seg(hex3), .page(page3), .frozen(frozen3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lit-segment patterns (gfedcba), inverted for the active-low pins.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic logic [55:0] render(input logic [79:0] snap, input int pg);
    logic [55:0] r;
    for (int d = 0; d < 8; d++) begin
      int slot = 3 - d / 2;
      int ch   = pg * 4 + slot;
      if (ch >= NCH) r[7*d +: 7] = 7'h7F;
      else r[7*d +: 7] = glyph(snap[ch*16 + (d % 2)*4 +: 4]);
    end
    return r;
  endfunction

  // Model state: m_hist[i] is the button level sampled i+1 edges ago.
  int          m_page = 0;
  int          m_cnt = 0;
  bit [3:0]    m_hist = '0;
  logic [79:0] m_snap = '0;
  logic [55:0] m_hex = {8{7'h7F}};
  bit          m_frozen = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_page = 0; m_cnt = 0; m_hist = '0; m_snap = '0;
      m_hex = {8{7'h7F}}; m_frozen = 1'b0;
    end else begin
      bit adv_btn, tc, adv;
      adv_btn = m_hist[2] && !m_hist[3];
      tc      = auto_m && (m_cnt == DIV - 1);
      adv     = adv_btn || tc;
      m_hex   = render(m_snap, m_page);
      if (adv) m_page = (m_page + 1) % 2;
      m_cnt   = (!auto_m || adv) ? 0 : m_cnt + 1;
      if (!frz) m_snap = ch_data;
      m_frozen = frz;
      m_hist  = {m_hist[2:0], btn};
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_hex", 64'(hex_seg), 64'(m_hex));
      check("model_page", 64'(page), 64'(m_page));
      check("model_frozen", 64'(frozen), 64'(m_frozen));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit which3);
    if (which3) btn3 = 1'b1; else btn = 1'b1;
    tick(1);
    btn3 = 1'b0;
    btn  = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    checking = 1'b1;
    tick(3);
    check("reset_hex", 64'(hex_seg), 64'({8{7'h7F}}));
    check("reset_page", 64'(page), 64'd0);

    rst_n = 1'b1;
    tick(1);
    check("first_zero", 64'(hex_seg), 64'({8{7'h40}}));

    ch_data = {16'h0057, 16'h0009, 16'hFFFF, 16'h0034, 16'h12AB};
    tick(2);
    check("map_p0", 64'(hex_seg),
          64'({7'h08, 7'h03, 7'h30, 7'h19, 7'h0E, 7'h0E, 7'h40, 7'h10}));

    pulse(1'b0);
    tick(2);
    check("btn_lat_hold", 64'(page), 64'd0);
    tick(1);
    check("btn_lat_page", 64'(page), 64'd1);
    tick(1);
    check("map_p1", 64'(hex_seg), 64'({7'h12, 7'h78, {6{7'h7F}}}));

    pulse(1'b0);
    tick(3);
    check("wrap_p0", 64'(page), 64'd0);
    pulse(1'b0);
    tick(3);
    check("wrap_p1", 64'(page), 64'd1);

    btn = 1'b1;
    tick(100);
    btn = 1'b0;
    tick(5);
    check("held_once", 64'(page), 64'd0);

    auto_m = 1'b1;
    tick(3);
    check("auto_hold", 64'(page), 64'd0);
    tick(1);
    check("auto_step1", 64'(page), 64'd1);
    tick(3);
    check("auto_hold2", 64'(page), 64'd1);
    tick(1);
    check("auto_step2", 64'(page), 64'd0);
    pulse(1'b0);
    tick(2);
    check("coinc_before", 64'(page), 64'd0);
    tick(1);
    check("coinc_single", 64'(page), 64'd1);
    tick(3);
    check("coinc_restart", 64'(page), 64'd1);
    tick(1);
    check("coinc_next", 64'(page), 64'd0);
    auto_m = 1'b0;

    ch_data[15:0] = 16'h0011;
    tick(2);
    frz = 1'b1;
    tick(1);
    ch_data[15:0] = 16'h0022;
    tick(5);
    check("frz_hold", 64'(hex_seg[55:42]), 64'({7'h79, 7'h79}));
    check("frz_flag", 64'(frozen), 64'd1);
    frz = 1'b0;
    tick(1);
    check("frz_lat", 64'(hex_seg[55:42]), 64'({7'h79, 7'h79}));
    tick(1);
    check("frz_release", 64'(hex_seg[55:42]), 64'({7'h24, 7'h24}));

    check("sw_p0", 64'(page3), 64'd0);
    check("sw_hex0", 64'(hex3), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
    pulse(1'b1);
    tick(3);
    check("sw_p1", 64'(page3), 64'd1);
    pulse(1'b1);
    tick(3);
    check("sw_p2", 64'(page3), 64'd2);
    tick(1);
    check("sw_hex2", 64'(hex3), 64'({7'h10, 7'h08, 7'h03, 7'h46}));
    pulse(1'b1);
    tick(3);
    check("sw_wrap", 64'(page3), 64'd0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      ch_data = 80'({$urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      if ($urandom_range(0, 15) == 0) frz = ~frz;
      if ($urandom_range(0, 63) == 0) auto_m = ~auto_m;
      if (cyc == 700 || cyc == 1400) begin
        rst_n = 1'b0;
        #1;
        check("midrun_rst_hex", 64'(hex_seg), 64'({8{7'h7F}}));
        check("midrun_rst_page", 64'(page), 64'd0);
        tick(3);
        rst_n = 1'b1;
      end
      tick(1);
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
